// File: rtl/seg_blink_controller.sv
// seg_blink_controller
// Drives NUM_DIGITS seven-segment channels, blinking or blanking the
// selected digits according to a two-bit mode. A prescaler sets the blink
// half-period (HALF_CYCLES for slow, a quarter of that for fast) and pulses
// tick on each phase toggle.
//
// Optional feature macro: SEG_BLINK_SYNC_RESTART_EN
//   defined   -> a change of sel while blinking restarts the blink period,
//                so a newly selected digit begins with a full visible half.
//   undefined -> sel has no influence on the prescaler, which free-runs.
module seg_blink_controller #(
    parameter int                NUM_DIGITS  = 4,
    parameter int                SEG_W       = 7,
    parameter int                HALF_CYCLES = 25000000,
    parameter logic [SEG_W-1:0]  BLANK_PAT   = '1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIGITS*SEG_W-1:0] digit_in,
    input  logic [NUM_DIGITS-1:0]       sel,
    input  logic [1:0]                  mode,
    output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
    output logic                        phase,
    output logic                        tick
);

    localparam int CNT_W = $clog2(HALF_CYCLES);
    localparam logic [CNT_W-1:0] TC_SLOW = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_FAST = CNT_W'(HALF_CYCLES / 4 - 1);

    localparam logic [1:0] MODE_STEADY = 2'b00;
    localparam logic [1:0] MODE_SLOW   = 2'b01;
    localparam logic [1:0] MODE_FAST   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [CNT_W-1:0]            prescaleCnt;
    logic [1:0]                  prevMode;
    logic                        modeBlinks;
    logic [CNT_W-1:0]            termCount;
    logic                        restart;
    logic [NUM_DIGITS*SEG_W-1:0] segNext;

    assign modeBlinks = (mode == MODE_SLOW) || (mode == MODE_FAST);
    assign termCount  = (mode == MODE_FAST) ? TC_FAST : TC_SLOW;

`ifdef SEG_BLINK_SYNC_RESTART_EN
    logic [NUM_DIGITS-1:0] prevSel;

    assign restart = (mode != prevMode) || (modeBlinks && (sel != prevSel));

    // Remember last cycle's selection so a selection change can restart the blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            prevSel <= '0;
        end else begin
            prevSel <= sel;
        end
    end
`else
    assign restart = (mode != prevMode);
`endif

    // Prescaler, blink phase and tick; restart dominates the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaleCnt <= '0;
            phase       <= 1'b1;
            tick        <= 1'b0;
            prevMode    <= MODE_STEADY;
        end else begin
            prevMode <= mode;
            if (restart || !modeBlinks) begin
                prescaleCnt <= '0;
                phase       <= 1'b1;
                tick        <= 1'b0;
            end else if (prescaleCnt >= termCount) begin
                // >= rather than == keeps the counter bounded even if the
                // terminal count ever shrinks beneath it.
                prescaleCnt <= '0;
                phase       <= ~phase;
                tick        <= 1'b1;
            end else begin
                prescaleCnt <= prescaleCnt + CNT_W'(1);
                tick        <= 1'b0;
            end
        end
    end

    // Per-digit blanking decision from the current inputs and registered phase.
    always_comb begin
        segNext = digit_in;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i] && ((modeBlinks && !phase) || (mode == MODE_HOLD))) begin
                segNext[i*SEG_W +: SEG_W] = BLANK_PAT;
            end
        end
    end

    // Register the segment outputs; reset shows every digit blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out <= {NUM_DIGITS{BLANK_PAT}};
        end else begin
            seg_out <= segNext;
        end
    end

endmodule

// File: doc/seg_blink_controller.md
SEG_BLINK_CONTROLLER -- requirements
Module: seg_blink_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of seven-segment digit channels, min 1.
REQ-002 Parameter SEG_W, default 7, segment bits per digit.
REQ-003 Parameter HALF_CYCLES, default 25000000, clock cycles per slow-blink half-period; multiple of 4, min 4.
REQ-004 Parameter BLANK_PAT, default all ones (7'h7F), segment pattern driven for a blanked digit (active-low display).
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 digit_in  input  NUM_DIGITS*SEG_W  packed segment patterns; digit i at [i*SEG_W +: SEG_W].
REQ-008 sel  input  NUM_DIGITS  per-digit blink enable; 1 = digit subject to blinking/blanking.
REQ-009 mode  input  2  00 steady, 01 slow blink, 10 fast blink, 11 hold-blank.
REQ-010 seg_out  output  NUM_DIGITS*SEG_W  registered segment patterns, same packing as digit_in.
REQ-011 phase  output  1  blink phase; 1 = visible half, 0 = blank half.
REQ-012 tick  output  1  one-cycle pulse on each phase toggle.

Function
REQ-013 Internal prescaler counter, width clog2(HALF_CYCLES), counts 0..TC; TC = HALF_CYCLES-1 in mode 01, HALF_CYCLES/4-1 in mode 10.
REQ-014 Counter at TC in mode 01/10: next cycle counter = 0, phase inverts, tick = 1; otherwise counter increments, tick = 0.
REQ-015 Modes 00 and 11: counter held at 0, phase held at 1, tick held at 0.
REQ-016 Any change of mode (vs registered previous mode) restarts: next cycle counter = 0, phase = 1, tick = 0.
REQ-017 Restart and TC in same cycle: restart wins, tick = 0.
REQ-018 Digit i blanked iff sel[i] = 1 and ((mode in {01,10} and phase = 0) or mode = 11).
REQ-019 seg_out digit i = BLANK_PAT if blanked, else digit_in digit i; registered, one cycle latency from digit_in/sel/mode/phase.
REQ-020 Unselected digits track digit_in with one cycle latency in every mode.
REQ-021 Counter never exceeds HALF_CYCLES-1; no wrap beyond TC.

Reset
REQ-022 rst = 1 at a rising edge: counter = 0, phase = 1, tick = 0, every seg_out digit = BLANK_PAT, previous mode = 00, previous sel = 0.
REQ-023 rst asserted mid-period overrides all other events in that cycle; counting resumes from 0 on first cycle after rst deasserts.

Configuration
REQ-024 Macro SEG_BLINK_SYNC_RESTART_EN defined: any change of sel (vs registered previous sel) while mode is 01/10 triggers the REQ-016 restart, so a newly selected digit starts a full visible half.
REQ-025 Macro SEG_BLINK_SYNC_RESTART_EN undefined: sel changes have no effect on counter or phase; prescaler free-runs; previous-sel register omitted.

Verification (NUM_DIGITS=4, SEG_W=7, HALF_CYCLES=8, BLANK_PAT=7'h7F)
REQ-026 rst high 2 cycles, digit_in all 7'h40 -> seg_out all 7'h7F, phase 1, tick 0; first cycle after release seg_out all 7'h40 (mode 00).
REQ-027 mode 01, sel 4'b0010, digit1 7'h40, others 7'h79 -> digit1 alternates 8 cycles 7'h40 / 8 cycles 7'h7F; digits 0,2,3 steady 7'h79; tick every 8 cycles.
REQ-028 mode 10, same stimulus -> digit1 alternates 2 cycles 7'h40 / 2 cycles 7'h7F; tick every 2 cycles.
REQ-029 mode 11, sel 4'b1001 -> digits 0 and 3 steady 7'h7F, digits 1,2 show digit_in; phase 1, tick never asserted.
REQ-030 mode 01, during blank half change sel 4'b0010->4'b0100 -> macro defined: next cycle phase 1, digit2 visible 8 full cycles; macro undefined: phase continues unchanged, digit2 blanked for remainder of current half.
REQ-031 mode 01, assert rst at counter = 5 in blank half -> next cycle reset values per REQ-022; after release first tick 8 cycles later.
